// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction memory responder with fetch PC and boot-load port
// LOAD fills the program store; RUN serves one registered word per rom_rd strobe.
module imem_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_rd,
  output logic [DATA_W-1:0] ROM_data,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              boot_skip,
  output logic              load_ready,
  output logic              running
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] lptr;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              mem_we;
  logic              lptr_full;

  assign mem_we    = (state == LOAD) && load_valid;
  assign lptr_full = (lptr == {ADDR_W{1'b1}});

  // The store has no reset so a boot_skip after reset keeps the previous image.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[lptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      lptr       <= '0;
      pc         <= '0;
      ROM_data   <= '0;
      load_ready <= 1'b1;
      running    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            if (!lptr_full) begin
              lptr <= lptr + 1'b1;
            end
            if (load_last || boot_skip || lptr_full) begin
              state      <= RUN;
              pc         <= '0;
              load_ready <= 1'b0;
              running    <= 1'b1;
            end
          end else if (boot_skip) begin
            state      <= RUN;
            pc         <= '0;
            load_ready <= 1'b0;
            running    <= 1'b1;
          end
        end
        RUN: begin
          // A redirect inserts a null-instruction bubble while the new target is loaded.
          if (redirect_en) begin
            pc       <= redirect_addr;
            ROM_data <= '0;
          end else if (rom_rd) begin
            ROM_data <= mem[pc];
            pc       <= pc + 1'b1;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - self-checking bench for imem_fetch
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_rd;
  logic [15:0] ROM_data;
  logic [7:0]  pc;
  logic        redirect_en;
  logic [7:0]  redirect_addr;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        boot_skip;
  logic        load_ready;
  logic        running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        red;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[20];

  imem_fetch #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .rom_rd(rom_rd), .ROM_data(ROM_data), .pc(pc),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .boot_skip(boot_skip), .load_ready(load_ready), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rom_rd = 1'b0; redirect_en = 1'b0; redirect_addr = 8'h00;
    load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0; boot_skip = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  function automatic vec_t mk(logic rd, logic red, logic [7:0] a, logic [15:0] d, logic [7:0] p);
    vec_t v;
    v.rd = rd; v.red = red; v.addr = a; v.data = d; v.pc = p;
    return v;
  endfunction

  logic [15:0] img [4];

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, 8'h00, 16'h1041, 8'd1);
    vecs[1]  = mk(1'b1, 1'b0, 8'h00, 16'h1082, 8'd2);
    vecs[2]  = mk(1'b1, 1'b0, 8'h00, 16'h0000, 8'd3);
    vecs[3]  = mk(1'b1, 1'b0, 8'h00, 16'h7005, 8'd4);
    vecs[4]  = mk(1'b1, 1'b0, 8'h00, 16'h0004, 8'd5);
    vecs[5]  = mk(1'b1, 1'b1, 8'h01, 16'h0000, 8'd1);
    vecs[6]  = mk(1'b1, 1'b0, 8'h00, 16'h1082, 8'd2);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 16'h1082, 8'd2);
    vecs[8]  = mk(1'b0, 1'b0, 8'h00, 16'h1082, 8'd2);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 16'h1082, 8'd2);
    vecs[10] = mk(1'b1, 1'b0, 8'h00, 16'h0000, 8'd3);
    vecs[11] = mk(1'b1, 1'b0, 8'h00, 16'h7005, 8'd4);
    vecs[12] = mk(1'b1, 1'b0, 8'h00, 16'h0004, 8'd5);
    vecs[13] = mk(1'b1, 1'b0, 8'h00, 16'h0005, 8'd6);
    vecs[14] = mk(1'b1, 1'b1, 8'h03, 16'h0000, 8'd3);
    vecs[15] = mk(1'b1, 1'b0, 8'h00, 16'h7005, 8'd4);
    vecs[16] = mk(1'b1, 1'b1, 8'h10, 16'h0000, 8'd16);
    vecs[17] = mk(1'b0, 1'b1, 8'h20, 16'h0000, 8'd32);
    vecs[18] = mk(1'b1, 1'b1, 8'h10, 16'h0000, 8'd16);
    vecs[19] = mk(1'b1, 1'b0, 8'h00, 16'h0010, 8'd17);
    img[0] = 16'h1041; img[1] = 16'h1082; img[2] = 16'h0000; img[3] = 16'h7005;

    idle_inputs();
    rst = 1'b0;
    #12;
    check("reset_rom_data", {16'h0, ROM_data}, 32'h0);
    check("reset_pc", {24'h0, pc}, 32'h0);
    check("reset_load_ready", {31'h0, load_ready}, 32'h1);
    check("reset_running", {31'h0, running}, 32'h0);
    rst = 1'b1;
    step();

    // Full image without load_last; RUN must begin only after word 255.
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = 16'(i);
      step();
      check("full_running", {31'h0, running}, (i == 255) ? 32'h1 : 32'h0);
    end
    load_valid = 1'b0;
    check("full_pc_start", {24'h0, pc}, 32'h0);
    check("full_load_ready", {31'h0, load_ready}, 32'h0);
    rom_rd = 1'b1;
    for (int k = 0; k < 258; k++) begin
      step();
      check("wrap_data", {16'h0, ROM_data}, 32'(k % 256));
      check("wrap_pc", {24'h0, pc}, 32'((k + 1) % 256));
    end
    rom_rd = 1'b0;

    // Boot skip keeps the store: mem[0] is still 0000.
    do_reset();
    boot_skip = 1'b1;
    step();
    boot_skip = 1'b0;
    check("skip_running", {31'h0, running}, 32'h1);
    rom_rd = 1'b1;
    step();
    rom_rd = 1'b0;
    check("skip_data", {16'h0, ROM_data}, 32'h0000);
    check("skip_pc", {24'h0, pc}, 32'h1);

    // Four-word boot image with load_last on the last word.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = (i == 3);
      step();
      check("boot_running", {31'h0, running}, (i == 3) ? 32'h1 : 32'h0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("boot_pc", {24'h0, pc}, 32'h0);
    check("boot_rom_data", {16'h0, ROM_data}, 32'h0);

    // Loads in RUN must be ignored, so drive a stray word throughout the table.
    load_valid = 1'b1; load_data = 16'hFFFF; load_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rom_rd = vecs[i].rd;
      redirect_en = vecs[i].red;
      redirect_addr = vecs[i].addr;
      step();
      check($sformatf("vec%0d_data", i), {16'h0, ROM_data}, {16'h0, vecs[i].data});
      check($sformatf("vec%0d_pc", i), {24'h0, pc}, {24'h0, vecs[i].pc});
      check($sformatf("vec%0d_running", i), {31'h0, running}, 32'h1);
    end
    idle_inputs();

    // Asynchronous reset mid-fetch, between clock edges.
    rom_rd = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async_rom_data", {16'h0, ROM_data}, 32'h0);
    check("async_pc", {24'h0, pc}, 32'h0);
    check("async_running", {31'h0, running}, 32'h0);
    check("async_load_ready", {31'h0, load_ready}, 32'h1);
    rst = 1'b1;
    rom_rd = 1'b1; redirect_en = 1'b1; redirect_addr = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("load_rd_pc", {24'h0, pc}, 32'h0);
      check("load_rd_data", {16'h0, ROM_data}, 32'h0);
      check("load_rd_ready", {31'h0, load_ready}, 32'h1);
    end
    idle_inputs();

    // load_last without load_valid is ignored; boot_skip with load_valid writes then runs.
    load_last = 1'b1;
    step();
    load_last = 1'b0;
    check("last_no_valid", {31'h0, running}, 32'h0);
    boot_skip = 1'b1; load_valid = 1'b1; load_data = 16'hABCD;
    step();
    idle_inputs();
    check("skipw_running", {31'h0, running}, 32'h1);
    rom_rd = 1'b1;
    step();
    check("skipw_data0", {16'h0, ROM_data}, 32'hABCD);
    step();
    rom_rd = 1'b0;
    check("skipw_data1", {16'h0, ROM_data}, 32'h1082);
    check("skipw_pc", {24'h0, pc}, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
